// File: rtl/nes_pkg.sv
// nes_pkg: FSM state type and NES button bit positions shared by the pad reader.
package nes_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
endpackage

// File: rtl/nes_sync.sv
// nes_sync: two-flop synchroniser, W bits wide.
module nes_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0;
      q <= '0;
    end else begin
      m <= d;
      q <= m;
    end
  end
endmodule

// File: rtl/nes_multi_pad_reader.sv
// nes_multi_pad_reader: polls NUM_PADS NES/SNES pads in parallel over shared latch/clock lines.
// Define NES_CONNECT_DETECT_EN to add one extra clock pair that reports pad presence on connected.
module nes_multi_pad_reader
  import nes_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int BITS     = 8,
  parameter int HALF_CYC = 151,
  parameter int POLL_CYC = 419583
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     poll_req,
  input  logic [NUM_PADS-1:0]      pad_data,
  output logic                     nes_latch,
  output logic                     nes_clk,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic [NUM_PADS*BITS-1:0] pressed,
  output logic                     frame_valid
`ifdef NES_CONNECT_DETECT_EN
  ,
  output logic [NUM_PADS-1:0]      connected
`endif
);
`ifdef NES_CONNECT_DETECT_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam int NP = BITS - 1 + D;
  localparam int CW = $clog2(2 * HALF_CYC);
  localparam int PW = $clog2(POLL_CYC);
  localparam int BW = $clog2(BITS + 2);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_ctr;
  logic [BW-1:0] bit_cnt;
  logic [NUM_PADS-1:0] sync_q;
  logic [NUM_PADS*BITS-1:0] sr, sr_n, frame;
  logic last, wrap, start, sample, shift;

  nes_sync #(.W(NUM_PADS)) u_sync (.clk(clk), .rst(rst), .d(pad_data), .q(sync_q));

  assign wrap   = poll_ctr == PW'(POLL_CYC - 1);
  assign start  = state == IDLE && (wrap || poll_req);
  assign last   = cnt == (state == LATCH ? CW'(2 * HALF_CYC - 1) : CW'(HALF_CYC - 1));
  assign sample = last && (state == LATCH || state == CLK_LO);
  // The presence sample (after bit BITS-1) must not disturb the button shift register
  assign shift  = sample && (state == LATCH || bit_cnt != BW'(BITS - 1));

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [BITS:0] t;
    assign t = {~sync_q[p], sr[p*BITS +: BITS]};
    assign sr_n[p*BITS +: BITS] = t[BITS:1];
`ifdef NES_CONNECT_DETECT_EN
    assign frame[p*BITS +: BITS] = sync_q[p] ? '0 : sr[p*BITS +: BITS];
`else
    assign frame[p*BITS +: BITS] = sr_n[p*BITS +: BITS];
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LATCH : IDLE;
      LATCH:   state_n = last ? (NP == 0 ? DONE : CLK_HI) : LATCH;
      CLK_HI:  state_n = last ? CLK_LO : CLK_HI;
      CLK_LO:  state_n = last ? (bit_cnt == BW'(NP - 1) ? DONE : CLK_HI) : CLK_LO;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from state_n so they line up exactly with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      poll_ctr    <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      nes_latch   <= 1'b0;
      nes_clk     <= 1'b0;
      buttons     <= '0;
      pressed     <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= state_n != state ? '0 : cnt + 1'b1;
      poll_ctr    <= (wrap || start) ? '0 : poll_ctr + 1'b1;
      bit_cnt     <= start ? '0 : (state == CLK_LO && last) ? bit_cnt + 1'b1 : bit_cnt;
      sr          <= shift ? sr_n : sr;
      nes_latch   <= state_n == LATCH;
      nes_clk     <= state_n == CLK_HI;
      frame_valid <= state_n == DONE;
      pressed     <= state_n == DONE ? frame & ~buttons : '0;
      buttons     <= state_n == DONE ? frame : buttons;
    end
  end

`ifdef NES_CONNECT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) connected <= '0;
    else if (state_n == DONE) connected <= ~sync_q;
  end
`endif
endmodule

// File: tb/tb_nes_multi_pad_reader.sv
// tb_nes_multi_pad_reader: directed scoreboard bench with a shift-register pad model.
module tb_nes_multi_pad_reader;
`ifdef NES_CONNECT_DETECT_EN
  localparam int NP = 8;
`else
  localparam int NP = 7;
`endif
  typedef struct packed {
    logic [15:0] b;
    logic [15:0] p;
    logic [1:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic poll_req = 1'b0;
  logic [1:0] pad_data;
  logic nes_latch, nes_clk, frame_valid;
  logic [15:0] buttons, pressed;
`ifdef NES_CONNECT_DETECT_EN
  logic [1:0] connected;
`endif
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [15:0] model_b = '0;
  logic [15:0] vis_b = '0;
  logic [7:0] wire0 = 8'hFF;
  logic [7:0] wire1 = 8'hFF;
  logic plug1 = 1'b1;
  logic [8:0] sh0 = '1;
  logic [8:0] sh1 = '1;
  logic nc_d = 1'b0;

  nes_multi_pad_reader #(.NUM_PADS(2), .BITS(8), .HALF_CYC(4), .POLL_CYC(200)) dut (
    .clk(clk), .rst(rst), .poll_req(poll_req), .pad_data(pad_data),
    .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
    .pressed(pressed), .frame_valid(frame_valid)
`ifdef NES_CONNECT_DETECT_EN
    , .connected(connected)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4021-style pad: parallel load while latch is high, shift on nes_clk rise, ground fills in
  always @(negedge clk) begin
    if (nes_latch) begin
      sh0 <= {1'b0, wire0};
      sh1 <= {1'b0, wire1};
    end else if (nes_clk && !nc_d) begin
      sh0 <= sh0 >> 1;
      sh1 <= sh1 >> 1;
    end
    nc_d <= nes_clk;
  end
  assign pad_data = {plug1 ? sh1[0] : 1'b1, sh0[0]};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] w0, input logic [7:0] w1, input logic pl1);
    exp_t e;
    wire0 = w0;
    wire1 = w1;
    plug1 = pl1;
    e.b = {pl1 ? ~w1 : 8'h00, ~w0};
    e.p = e.b & ~model_b;
    e.c = {pl1, 1'b1};
    model_b = e.b;
    sb.push_back(e);
  endtask

  task automatic wait_latch(input string tag, output int t);
    for (int i = 0; i < 400 && !nes_latch; i++) step();
    check({tag, "_latch_seen"}, nes_latch, 1);
    t = cyc;
  endtask

  task automatic frame_check(input string tag, input int req_at);
    int t0, lat, pulses, bad, i;
    logic pc;
    exp_t e;
    t0 = cyc;
    lat = 0;
    pulses = 0;
    bad = 0;
    i = 0;
    pc = 1'b0;
    while (nes_latch && lat < 50) begin
      poll_req = (lat == req_at);
      lat++;
      step();
    end
    while (!frame_valid && i < 200) begin
      if (nes_clk !== ((i % 8) < 4)) bad++;
      if (buttons !== vis_b || frame_valid !== 1'b0 || pressed !== '0) bad++;
      if (nes_clk && !pc) pulses++;
      pc = nes_clk;
      poll_req = (lat + i == req_at);
      step();
      i++;
    end
    poll_req = 1'b0;
    check({tag, "_latch_len"}, lat, 8);
    check({tag, "_clk_pulses"}, pulses, NP);
    check({tag, "_waveform"}, bad, 0);
    check({tag, "_fv_offset"}, cyc - t0, 8 + NP * 8);
    check({tag, "_sb_nonempty"}, sb.size(), 1);
    e = sb.size() > 0 ? sb.pop_front() : '0;
    check({tag, "_buttons"}, buttons, e.b);
    check({tag, "_pressed"}, pressed, e.p);
`ifdef NES_CONNECT_DETECT_EN
    check({tag, "_connected"}, connected, e.c);
`endif
    vis_b = e.b;
    step();
    check({tag, "_fv_drop"}, frame_valid, 0);
    check({tag, "_pressed_drop"}, pressed, 0);
    check({tag, "_buttons_hold"}, buttons, e.b);
  endtask

  initial begin
    int t_rel, t1, t3, t4, t5, t6, t7, t_rst, seen;
    repeat (3) step();
    check("rst_latch", nes_latch, 0);
    check("rst_clk", nes_clk, 0);
    check("rst_buttons", buttons, 0);
    check("rst_pressed", pressed, 0);
    check("rst_fv", frame_valid, 0);
`ifdef NES_CONNECT_DETECT_EN
    check("rst_connected", connected, 0);
`endif
    rst = 1'b0;
    t_rel = cyc;
    push_frame(8'hFE, 8'hFF, 1'b1);
    wait_latch("f1", t1);
    check("f1_first_poll", t1 - t_rel, 200);
    frame_check("f1", -1);
    push_frame(8'hFE, 8'hFF, 1'b1);
    wait_latch("f2", t1);
    frame_check("f2", -1);
    push_frame(8'hFE, 8'hFF, 1'b1);
    wait_latch("f3", t3);
    frame_check("f3", 10);
    seen = 0;
    repeat (50) begin
      step();
      if (nes_latch) seen++;
    end
    check("midframe_req_ignored", seen, 0);
    push_frame(8'hA5, 8'h7E, 1'b1);
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
    check("idle_req_latch", nes_latch, 1);
    t4 = cyc;
    frame_check("f4", -1);
    push_frame(8'h00, 8'hFF, 1'b0);
    wait_latch("f5", t5);
    check("f5_poll_period", t5 - t4, 200);
    frame_check("f5", -1);
    wire0 = 8'hFE;
    wire1 = 8'h00;
    plug1 = 1'b1;
    wait_latch("f6", t6);
    check("f6_poll_period", t6 - t5, 200);
    repeat (25) step();
    check("abort_clk_hi", nes_clk, 1);
    rst = 1'b1;
    step();
    t_rst = cyc;
    rst = 1'b0;
    check("abort_clk", nes_clk, 0);
    check("abort_latch", nes_latch, 0);
    check("abort_buttons", buttons, 0);
    model_b = '0;
    vis_b = '0;
    seen = 0;
    repeat (150) begin
      step();
      if (frame_valid || nes_latch) seen++;
    end
    check("abort_no_frame", seen, 0);
    push_frame(8'hFE, 8'hFF, 1'b1);
    wait_latch("f7", t7);
    check("f7_poll_after_reset", t7 - t_rst, 200);
    frame_check("f7", -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
